counter_4bit: RTL and testbench

//   Free-running synchronous up-counter, 4 bits by default, with an optional modulus.

---
 rtl/counter_4bit_if.sv | 33 +++
 rtl/counter_4bit.sv | 62 ++++++
 tb/tb_counter_4bit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/counter_4bit_if.sv
// rtl/counter_4bit_if.sv - Output bundle of the free-running counter
//
// Purpose: groups the counter's observable outputs so producer and consumers
// share one typed connection.
//
// Signals:
//   count  WIDTH  current registered count
//   tc     1      terminal count, high while count equals the terminal value
//   wrap   1      registered one-cycle pulse following a terminal->0 rollover
//
// Modports:
//   master  drives count/tc/wrap (the counter itself)
//   slave   observes count/tc/wrap (surrounding logic)

interface counter_4bit_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output count,
        output tc,
        output wrap
    );

    modport slave (
        input count,
        input tc,
        input wrap
    );
endinterface

// File: rtl/counter_4bit.sv
// rtl/counter_4bit.sv - Free-running modulo up-counter with terminal-count and wrap flags
//
// Purpose: timebase / sequence index. Advances once per clock, wraps to zero
// after MAX_VALUE, flags the terminal value combinationally and pulses wrap
// for one cycle after each rollover.
//
// Parameters:
//   WIDTH      counter width in bits (>= 1)
//   MAX_VALUE  terminal value, 0 < MAX_VALUE <= 2^WIDTH-1
//
// Ports:
//   clk    in   rising-edge clock for all state
//   rst_n  in   synchronous reset, active HIGH despite its name
//   cnt    master modport carrying count, tc, wrap

module counter_4bit #(
    parameter int          WIDTH     = 4,
    parameter int unsigned MAX_VALUE = (1 << WIDTH) - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    counter_4bit_if.master cnt
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max;

    assign at_max = (count_q == MAX_V);

    // The >= comparison also folds any out-of-range value back to zero; only
    // a genuine terminal value raises the wrap pulse.
    always_comb begin
        count_d = count_q + WIDTH'(1);
        wrap_d  = 1'b0;
        if (count_q >= MAX_V) begin
            count_d = '0;
            wrap_d  = at_max;
        end
    end

    // rst_n is active high: a 1 sampled on an edge clears the counter and
    // suppresses any wrap pulse, even when the count sits at MAX_V.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign cnt.count = count_q;
    assign cnt.tc    = at_max;
    assign cnt.wrap  = wrap_q;

endmodule

// File: tb/tb_counter_4bit.sv
// tb/tb_counter_4bit.sv - Directed scoreboard bench for counter_4bit

module tb_counter_4bit;

    logic clk;
    logic rst_a;
    logic rst_b;
    logic rst_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    counter_4bit_if #(.WIDTH(4)) if_a ();
    counter_4bit_if #(.WIDTH(4)) if_b ();
    counter_4bit_if #(.WIDTH(8)) if_c ();

    counter_4bit #(.WIDTH(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .cnt   (if_a)
    );

    counter_4bit #(.WIDTH(4), .MAX_VALUE(9)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .cnt   (if_b)
    );

    counter_4bit #(.WIDTH(8)) dut_c (
        .clk   (clk),
        .rst_n (rst_c),
        .cnt   (if_c)
    );

    typedef struct {
        int         dut;
        logic [7:0] count;
        logic       tc;
        logic       wrap;
        string      tag;
    } exp_t;

    exp_t sb[$];

    int n_vec  = 0;
    int n_miss = 0;
    int wraps_c = 0;

    int m_count [3];
    int m_wrap  [3];
    int m_max   [3];

    task automatic check();
        exp_t       e;
        logic [7:0] oc;
        logic       ot;
        logic       ow;
        n_vec++;
        assert (sb.size() != 0) else begin
            n_miss++;
            $error("FAIL sb_empty observed=0 entries expected>=1");
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        case (e.dut)
            0: begin oc = {4'b0, if_a.count}; ot = if_a.tc; ow = if_a.wrap; end
            1: begin oc = {4'b0, if_b.count}; ot = if_b.tc; ow = if_b.wrap; end
            default: begin oc = if_c.count; ot = if_c.tc; ow = if_c.wrap; end
        endcase
        n_vec++;
        assert (oc === e.count) else begin
            n_miss++;
            $error("FAIL %s_count observed=%0d expected=%0d", e.tag, oc, e.count);
        end
        n_vec++;
        assert (ot === e.tc) else begin
            n_miss++;
            $error("FAIL %s_tc observed=%b expected=%b (count=%0d)", e.tag, ot, e.tc, e.count);
        end
        n_vec++;
        assert (ow === e.wrap) else begin
            n_miss++;
            $error("FAIL %s_wrap observed=%b expected=%b (count=%0d)", e.tag, ow, e.wrap, e.count);
        end
        if (e.dut == 2 && ow === 1'b1) wraps_c++;
    endtask

    // Drive one clock edge on the selected counter, predict its outputs from
    // the modulo model, then compare #1 after the edge.
    task automatic step(input int d, input logic r, input string tag);
        exp_t e;
        @(negedge clk);
        case (d)
            0: rst_a = r;
            1: rst_b = r;
            default: rst_c = r;
        endcase
        if (r) begin
            m_count[d] = 0;
            m_wrap[d]  = 0;
        end else if (m_count[d] == m_max[d]) begin
            m_count[d] = 0;
            m_wrap[d]  = 1;
        end else begin
            m_count[d] = m_count[d] + 1;
            m_wrap[d]  = 0;
        end
        e.dut   = d;
        e.count = 8'(m_count[d]);
        e.tc    = (m_count[d] == m_max[d]);
        e.wrap  = (m_wrap[d] != 0);
        e.tag   = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        m_max[0] = 15;
        m_max[1] = 9;
        m_max[2] = 255;
        for (int i = 0; i < 3; i++) begin
            m_count[i] = 0;
            m_wrap[i]  = 0;
        end
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) step(0, 1'b1, "reset");

        // Free run through a full 15->0 rollover.
        for (int i = 0; i < 20; i++) step(0, 1'b0, "run");

        // Count 4 -> 7, reset mid-count, resume.
        for (int i = 0; i < 3; i++) step(0, 1'b0, "to7");
        step(0, 1'b1, "mid_reset");
        for (int i = 0; i < 3; i++) step(0, 1'b0, "resume");

        // Count 3 -> 15, reset exactly at the terminal value: wrap suppressed.
        for (int i = 0; i < 12; i++) step(0, 1'b0, "to15");
        step(0, 1'b1, "reset_at_max");
        for (int i = 0; i < 2; i++) step(0, 1'b0, "after_max_reset");

        // MAX_VALUE = 9.
        step(1, 1'b1, "mod9_reset");
        for (int i = 0; i < 12; i++) step(1, 1'b0, "mod9");

        // WIDTH = 8, default terminal value: 256 edges return to 0 with one wrap.
        step(2, 1'b1, "w8_reset");
        wraps_c = 0;
        for (int i = 0; i < 256; i++) step(2, 1'b0, "w8");
        n_vec++;
        assert (wraps_c == 1) else begin
            n_miss++;
            $error("FAIL w8_wrap_pulses observed=%0d expected=1", wraps_c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
